// File: rtl/if_fetch_stage_if.sv
// Fetch stage bus bundle: instruction memory request/response
// channel plus the valid/ready instruction stream to decode.
interface if_fetch_stage_if #(
   parameter int N = 64
);
   logic          imem_req;
   logic [N-1:0]  imem_addr;
   logic          imem_ready;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [N-1:0]  out_pc;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

// File: rtl/if_fetch_stage.sv
// LEGv8 instruction fetch: owns the PC, tracks in-flight fetches,
// buffers {instr, pc} for decode and squashes on redirect.
module if_fetch_stage #(
   parameter int           N        = 64,
   parameter logic [N-1:0] RESET_PC = '0,
   parameter int           DEPTH    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         redirect,
   input  logic [N-1:0] redirect_pc,
   if_fetch_stage_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [AW-1:0] ptr_t;

   logic [N-1:0]  pc;

   // In-order PCs of requests the memory has accepted.
   logic [N-1:0]  tag_q [DEPTH];
   ptr_t          tag_wr;
   ptr_t          tag_rd;
   cnt_t          outstanding;

   // Returned words waiting for decode.
   logic [31:0]   fifo_instr [DEPTH];
   logic [N-1:0]  fifo_pc    [DEPTH];
   ptr_t          fifo_wr;
   ptr_t          fifo_rd;
   cnt_t          fifo_cnt;

   // Responses still owed for fetches made before a redirect.
   cnt_t          discard;

   logic          req;
   logic          issue;
   logic          rsp;
   logic          keep;
   logic          vld;
   logic          pop;

   // Credit check, handshakes and response routing.
   always_comb begin
      req   = 1'b0;
      issue = 1'b0;
      rsp   = 1'b0;
      keep  = 1'b0;
      vld   = 1'b0;
      pop   = 1'b0;
      req   = !reset && !redirect &&
              ((outstanding + fifo_cnt) < cnt_t'(DEPTH));
      issue = req && bus.imem_ready;
      rsp   = bus.imem_rvalid && (outstanding != '0);
      keep  = rsp && !redirect && (discard == '0);
      vld   = !reset && !redirect && (fifo_cnt != '0);
      pop   = vld && bus.out_ready;
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc;
   assign bus.out_valid = vld;
   assign bus.out_instr = fifo_instr[fifo_rd];
   assign bus.out_pc    = fifo_pc[fifo_rd];

   // PC advance and in-flight tag tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         tag_wr      <= '0;
         tag_rd      <= '0;
         outstanding <= '0;
      end else begin
         if (redirect)
            pc <= redirect_pc;
         else if (issue)
            pc <= pc + N'(4);
         if (issue) begin
            tag_q[tag_wr] <= pc;
            tag_wr        <= tag_wr + 1'b1;
         end
         if (rsp)
            tag_rd <= tag_rd + 1'b1;
         outstanding <= outstanding + cnt_t'(issue)
                        - cnt_t'(rsp);
      end
   end

   // Decode-side buffer: fill from kept responses, drain on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_wr  <= '0;
         fifo_rd  <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
         end
      end else if (redirect) begin
         fifo_wr  <= '0;
         fifo_rd  <= '0;
         fifo_cnt <= '0;
      end else begin
         if (keep) begin
            fifo_instr[fifo_wr] <= bus.imem_rdata;
            fifo_pc[fifo_wr]    <= tag_q[tag_rd];
            fifo_wr             <= fifo_wr + 1'b1;
         end
         if (pop)
            fifo_rd <= fifo_rd + 1'b1;
         fifo_cnt <= fifo_cnt + cnt_t'(keep) - cnt_t'(pop);
      end
   end

   // Stale-response counter: everything still in flight after a
   // redirect cycle belongs to the old path.
   always_ff @(posedge clk) begin
      if (reset)
         discard <= '0;
      else if (redirect)
         discard <= outstanding - cnt_t'(rsp);
      else if (rsp && (discard != '0))
         discard <= discard - 1'b1;
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage with a
// variable-latency instruction memory model.
module tb_if_fetch_stage;
   localparam int           N      = 64;
   localparam int           DEPTH  = 2;
   localparam logic [N-1:0] RST_PC = '0;

   typedef struct {
      logic [N-1:0] addr;
      int           due;
   } req_t;

   typedef struct {
      logic [N-1:0] pc;
      logic [31:0]  instr;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         redirect = 1'b0;
   logic [N-1:0] redirect_pc = '0;

   if_fetch_stage_if #(.N(N)) bus ();

   if_fetch_stage #(
      .N(N),
      .RESET_PC(RST_PC),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int           cyc = 0;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_pop = 0;
   int           lat_fix = 1;
   int           last_due = 0;
   bit           spur = 1'b0;
   bit           spur_on = 1'b0;
   req_t         mq[$];
   exp_t         eq[$];
   logic [N-1:0] gen_pc = RST_PC;
   logic [N-1:0] fetch_pc = RST_PC;

   function automatic logic [31:0] word(input logic [N-1:0] a);
      return 32'hF800_0000 | a[31:0];
   endfunction

   task automatic chk(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, expv, cyc);
      end
   endtask

   // Expected decode stream: consecutive words from the current target.
   function automatic void topup();
      while (eq.size() < 8) begin
         exp_t e;
         e.pc    = gen_pc;
         e.instr = word(gen_pc);
         eq.push_back(e);
         gen_pc  = gen_pc + 64'd4;
      end
   endfunction

   function automatic void retarget(input logic [N-1:0] t);
      eq.delete();
      gen_pc   = t;
      fetch_pc = t;
      topup();
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
      topup();
   endtask

   task automatic do_reset(input int ncyc, input bit sp);
      reset = 1'b1;
      retarget(RST_PC);
      for (int i = 0; i < ncyc; i++) begin
         if (sp && i == ncyc - 1)
            spur = 1'b1;
         tick();
      end
      reset = 1'b0;
   endtask

   task automatic redirect_now(input logic [N-1:0] t);
      redirect    = 1'b1;
      redirect_pc = t;
      retarget(t);
      tick();
      redirect = 1'b0;
   endtask

   // Memory model: in-order responses, latency >= 1, reset with the DUT.
   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         spur_on = 1'b0;
         if (spur) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
            spur    = 1'b0;
            spur_on = 1'b1;
         end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word(mq[0].addr);
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
         end
         @(negedge clk);
         if (reset) begin
            mq.delete();
            last_due = 0;
         end else begin
            if (bus.imem_rvalid && !spur_on)
               void'(mq.pop_front());
            if (bus.imem_req && bus.imem_ready) begin
               req_t r;
               int   l;
               chk("fetch_addr", bus.imem_addr, fetch_pc);
               fetch_pc = fetch_pc + 64'd4;
               l = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
               r.addr = bus.imem_addr;
               r.due  = cyc + l;
               if (r.due < last_due)
                  r.due = last_due;
               last_due = r.due;
               mq.push_back(r);
            end
         end
      end
   end

   // Output monitor: squash rules and in-order stream comparison.
   always @(negedge clk) begin
      if (reset || redirect) begin
         chk("squash_valid", bus.out_valid, 0);
         chk("squash_req", bus.imem_req, 0);
      end else if (bus.out_valid && bus.out_ready) begin
         if (eq.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            exp_t e;
            e = eq.pop_front();
            n_pop++;
            chk("out_pc", bus.out_pc, e.pc);
            chk("out_instr", bus.out_instr, e.instr);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           k;
      logic [N-1:0] t;
      bus.imem_ready = 1'b1;
      bus.out_ready  = 1'b1;

      // Startup: reset state and first-valid latency.
      lat_fix = 1;
      do_reset(2, 1'b0);
      #2;
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_out_instr", bus.out_instr, 0);
      chk("rst_req", bus.imem_req, 1);
      k = 0;
      while (!bus.out_valid && k < 20) begin
         tick();
         #2;
         k++;
      end
      chk("first_valid_lat", k, 2);
      repeat (20) tick();

      // Decode stall: credits cap fetches at DEPTH.
      bus.out_ready = 1'b0;
      do_reset(1, 1'b0);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         #2;
         if (bus.imem_req && bus.imem_ready)
            k++;
         tick();
      end
      chk("stall_reqs", k, DEPTH);
      chk("stall_out_pc", bus.out_pc, RST_PC);
      chk("stall_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      #2;
      chk("req_at_pop", bus.imem_req, 0);
      tick();
      #2;
      chk("req_after_pop", bus.imem_req, 1);
      repeat (10) tick();

      // Redirect with two slow fetches in flight.
      lat_fix = 3;
      do_reset(1, 1'b0);
      k = 0;
      while (mq.size() < 2 && k < 30) begin
         tick();
         k++;
      end
      chk("two_inflight", mq.size(), 2);
      redirect_now(64'h100);
      #2;
      k = 0;
      while (!bus.out_valid && k < 30) begin
         tick();
         #2;
         k++;
      end
      chk("redir_pc", bus.out_pc, 64'h100);
      chk("redir_instr", bus.out_instr, word(64'h100));
      repeat (10) tick();

      // Redirect coinciding with a response.
      lat_fix = 1;
      k = 0;
      while (!bus.imem_rvalid && k < 30) begin
         tick();
         k++;
      end
      chk("rvalid_seen", bus.imem_rvalid, 1);
      redirect_now(64'h2000);
      #2;
      chk("post_redir_empty", bus.out_valid, 0);
      chk("post_redir_req", bus.imem_req, 1);
      chk("post_redir_addr", bus.imem_addr, 64'h2000);
      repeat (10) tick();

      // PC wrap at the top of the address space.
      redirect_now(64'hFFFF_FFFF_FFFF_FFF8);
      #2;
      chk("wrap_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
      repeat (15) tick();

      // Reset with fetches in flight, then a stray response.
      lat_fix = 3;
      k = 0;
      while (mq.size() < 2 && k < 30) begin
         tick();
         k++;
      end
      chk("two_inflight_rst", mq.size(), 2);
      do_reset(1, 1'b1);
      #2;
      chk("post_rst_valid", bus.out_valid, 0);
      chk("post_rst_req", bus.imem_req, 1);
      chk("post_rst_addr", bus.imem_addr, RST_PC);
      chk("post_rst_out_pc", bus.out_pc, 0);
      repeat (20) tick();

      // Random traffic with redirects and resets.
      lat_fix = 0;
      for (int c = 0; c < 1500; c++) begin
         int r;
         bus.imem_ready = ($urandom_range(0, 3) != 0);
         bus.out_ready  = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 99));
         t = '0;
         t[23:2] = 22'($urandom);
         if (r < 4) begin
            redirect_now(t);
         end else if (r == 4) begin
            redirect_now(t);
            t[23:2] = 22'($urandom);
            redirect_now(t);
         end else if (r == 5) begin
            do_reset(1, 1'($urandom_range(0, 1)));
         end else begin
            tick();
         end
      end
      bus.imem_ready = 1'b1;
      bus.out_ready  = 1'b1;
      repeat (30) tick();
      chk("liveness", (n_pop >= 200), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
